// File: rtl/uart_tx.sv
// uart_tx - UART transmitter, counterpart of the team's UART receiver.
//   Frame: start bit, PAYLOAD_BITS data bits LSB-first, optional even parity,
//   STOP_BITS stop bits. Line idles high. One word per valid/ready handshake.
// Ports:
//   clk        in   single clock, rising edge
//   tx_reset   in   asynchronous active-low reset
//   tx_enable  in   1: new words may be accepted
//   tx_data    in   word to send, sampled on handshake
//   tx_valid   in   tx_data valid
//   tx_ready   out  word can be accepted this cycle
//   tx_serial  out  serial line (registered)
//   tx_busy    out  frame in progress
//   tx_break   in   (UART_TX_BREAK_EN only) hold line low while idle
// Build option: define UART_TX_BREAK_EN to add the tx_break port and break logic.
module uart_tx #(
   parameter int unsigned PAYLOAD_BITS = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned BAUD_RATE    = 115_200,
   parameter int unsigned CLK_FREQ     = 8_000_000
) (
   input  logic                    clk,
   input  logic                    tx_reset,
   input  logic                    tx_enable,
   input  logic [PAYLOAD_BITS-1:0] tx_data,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   output logic                    tx_serial,
   output logic                    tx_busy
`ifdef UART_TX_BREAK_EN
   ,
   input  logic                    tx_break
`endif
);

   localparam int unsigned CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
   end
   if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9) begin : g_bad_payload
      $error("uart_tx: PAYLOAD_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK,
      S_MARK
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        clk_cnt_q, clk_cnt_d;
   logic [3:0]              bit_cnt_q, bit_cnt_d;
   logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
   logic                    parity_q, parity_d;
   logic                    serial_q, serial_d;
   logic                    busy_q, busy_d;
   logic                    idle_q, idle_d;
   logic                    bit_done;
   logic                    brk;

`ifdef UART_TX_BREAK_EN
   assign brk = tx_break;
`else
   assign brk = 1'b0;
`endif

   // idle_q is low out of reset, so tx_ready stays 0 until the first edge after release.
   assign tx_ready  = idle_q & tx_enable & ~brk;
   assign tx_serial = serial_q;
   assign tx_busy   = busy_q;
   assign bit_done  = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = bit_done ? '0 : clk_cnt_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            if (brk) begin
               state_d = S_BREAK;
            end else if (tx_valid && tx_ready) begin
               shift_d  = tx_data;
               parity_d = ^tx_data;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (bit_done) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == 4'(PAYLOAD_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_done) state_d = S_STOP;
         end
         S_STOP: begin
            if (bit_done) begin
               if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            clk_cnt_d = '0;
            if (!tx_break) state_d = S_MARK;
         end
         S_MARK: begin
            if (bit_done) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Line level follows the state being entered so the output stays a plain flop.
      case (state_d)
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = shift_d[0];
         S_PARITY: serial_d = parity_q;
         S_BREAK:  serial_d = 1'b0;
         default:  serial_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      idle_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge tx_reset) begin
      if (!tx_reset) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         serial_q  <= 1'b1;
         busy_q    <= 1'b0;
         idle_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         serial_q  <= serial_d;
         busy_q    <= busy_d;
         idle_q    <= idle_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx - directed + random frames on two uart_tx instances:
//   inst 0: defaults (8 data, even parity, 1 stop); inst 1: no parity, 2 stops.
module tb_uart_tx;

   localparam int CPB = 69;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] en, valid, rdy, ser, busy, brk;
   logic [7:0] data [2];

   int checks = 0;
   int errors = 0;
   int exp_q [$];

   always #5 clk = ~clk;

   uart_tx #(.PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY_EN(1),
             .BAUD_RATE(115_200), .CLK_FREQ(8_000_000)) dut0 (
      .clk(clk), .tx_reset(rst_n), .tx_enable(en[0]), .tx_data(data[0]),
      .tx_valid(valid[0]), .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(busy[0])
`ifdef UART_TX_BREAK_EN
      , .tx_break(brk[0])
`endif
   );

   uart_tx #(.PAYLOAD_BITS(8), .STOP_BITS(2), .PARITY_EN(0),
             .BAUD_RATE(115_200), .CLK_FREQ(8_000_000)) dut1 (
      .clk(clk), .tx_reset(rst_n), .tx_enable(en[1]), .tx_data(data[1]),
      .tx_valid(valid[1]), .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(busy[1])
`ifdef UART_TX_BREAK_EN
      , .tx_break(brk[1])
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected line level per bit slot, from the frame rules.
   function automatic void model_frame(input logic [7:0] d, input int pe, input int sb);
      int ones = 0;
      exp_q.delete();
      exp_q.push_back(0);
      for (int i = 0; i < 8; i++) begin
         int b = (int'(d) / (1 << i)) % 2;
         ones += b;
         exp_q.push_back(b);
      end
      if (pe != 0) exp_q.push_back(ones % 2);
      for (int i = 0; i < sb; i++) exp_q.push_back(1);
   endfunction

   // Called at a negedge. Sends d on instance s and checks every cycle of the frame.
   // drop_en >= 0 deasserts tx_enable at that cycle of the frame.
   task automatic send(input int s, input logic [7:0] d, input bit keep_valid, input int drop_en);
      int waitc = 0;
      int cyc = 0;
      int bad, busy_bad;
      while (rdy[s] !== 1'b1 && waitc < 2000) begin
         @(negedge clk);
         waitc++;
      end
      chk("ready_before_send", rdy[s], 1);
      data[s]  = d;
      valid[s] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep_valid) valid[s] = 1'b0;
      model_frame(d, (s == 0) ? 1 : 0, (s == 0) ? 1 : 2);
      busy_bad = 0;
      for (int b = 0; b < exp_q.size(); b++) begin
         bad = 0;
         for (int c = 0; c < CPB; c++) begin
            if (ser[s] !== exp_q[b][0]) bad++;
            if (busy[s] !== 1'b1) busy_bad++;
            if (cyc == drop_en) en[s] = 1'b0;
            cyc++;
            if (!keep_valid) data[s] = 8'($urandom);
            @(negedge clk);
         end
         chk($sformatf("inst%0d_data%02h_bit%0d_bad_cycles", s, d, b), bad, 0);
      end
      chk("busy_low_cycles_in_frame", busy_bad, 0);
      chk("busy_after_frame", busy[s], 0);
      chk("line_idle_after_frame", ser[s], 1);
   endtask

   initial begin
      int bad;
      rst_n = 1'b0;
      en = '0; valid = '0; brk = '0;
      data[0] = '0; data[1] = '0;

      // Reset state.
      repeat (5) @(negedge clk);
      chk("reset_serial", ser, 2'b11);
      chk("reset_ready", rdy, 2'b00);
      chk("reset_busy", busy, 2'b00);
      en = 2'b11;
      chk("ready_during_reset_with_enable", rdy, 2'b00);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", rdy, 2'b11);

      // Known word plus parity/stop slots.
      send(0, 8'hA5, 1'b0, -1);

      // Back-to-back with valid held: one idle cycle then next start bit.
      send(0, 8'h00, 1'b1, -1);
      chk("gap_ready", rdy[0], 1);
      send(0, 8'hFF, 1'b0, -1);

      // No parity, two stop bits.
      send(1, 8'h80, 1'b0, -1);

      // Reset during data bit 3 of 0x3C.
      data[0] = 8'h3C;
      valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (CPB + 3 * CPB + 30) @(negedge clk);
      chk("busy_before_midframe_reset", busy[0], 1);
      rst_n = 1'b0;
      #1;
      chk("serial_async_reset", ser[0], 1);
      chk("busy_async_reset", busy[0], 0);
      chk("ready_async_reset", rdy[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_second_release", rdy[0], 1);
      send(0, 8'h55, 1'b0, -1);

      // tx_enable dropped mid-frame.
      send(0, 8'($urandom), 1'b0, 300);
      valid[0] = 1'b1;
      bad = 0;
      repeat (20) begin
         if (rdy[0] !== 1'b0 || busy[0] !== 1'b0 || ser[0] !== 1'b1) bad++;
         @(negedge clk);
      end
      chk("disabled_idle_bad_cycles", bad, 0);
      valid[0] = 1'b0;
      en[0] = 1'b1;
      @(negedge clk);
      chk("ready_after_reenable", rdy[0], 1);

      // Random words on both frame formats.
      for (int i = 0; i < 4; i++) begin
         send(0, 8'($urandom), 1'b0, -1);
         send(1, 8'($urandom), 1'b0, -1);
      end

`ifdef UART_TX_BREAK_EN
      brk[0] = 1'b1;
      bad = 0;
      repeat (500) begin
         @(negedge clk);
         if (ser[0] !== 1'b0 || rdy[0] !== 1'b0) bad++;
      end
      chk("break_low_bad_cycles", bad, 0);
      brk[0] = 1'b0;
      bad = 0;
      repeat (CPB) begin
         @(negedge clk);
         if (ser[0] !== 1'b1 || rdy[0] !== 1'b0) bad++;
      end
      chk("break_mark_bad_cycles", bad, 0);
      @(negedge clk);
      chk("ready_after_break", rdy[0], 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
